// File: rtl/onfi_edge_detect.sv
// onfi_edge_detect: N-channel synchronise / debounce / edge-detect block with sticky
// interrupt flags, exposed as a wishbone slave on the onfi register bus.
module onfi_edge_detect #(
   parameter int CH_N      = 4,
   parameter int DB_CNT_W  = 16,
   parameter int MM_DATA_W = 32,
   parameter int MM_ADDR_W = 8
) (
   input  logic                 mm_clk_i,
   input  logic                 mm_rst_i,
   input  logic [CH_N-1:0]      sw_i,
   output logic [CH_N-1:0]      pulse_o,
   output logic                 irq_o,
   input  logic                 mm_cyc_i,
   input  logic                 mm_stb_i,
   input  logic [MM_ADDR_W-1:0] mm_addr_i,
   input  logic [MM_DATA_W-1:0] mm_dat_i,
   output logic [MM_DATA_W-1:0] mm_dat_o,
   input  logic                 mm_we_i,
   output logic                 mm_ack_o,
   output logic                 mm_err_o
);
   localparam int                WORD_W   = MM_ADDR_W - 2;
   localparam logic [2*CH_N-1:0] MODE_RST = {CH_N{2'b10}};

   logic [CH_N-1:0]      r_s1, r_sync, r_level, r_pulse, r_event, r_irq_en;
   logic [2*CH_N-1:0]    r_mode;
   logic [DB_CNT_W-1:0]  r_dbnc;
   logic [DB_CNT_W-1:0]  r_cnt [CH_N];
   logic                 r_ack, r_err;
   logic [MM_DATA_W-1:0] r_dat;

   logic [CH_N-1:0]      w_accept, w_hit, w_clr;
   logic [WORD_W-1:0]    w_word;
   logic                 w_acc, w_valid, w_wr;
   logic [MM_DATA_W-1:0] w_rdata;
   logic                 w_unused_ok;

   assign w_word  = mm_addr_i[MM_ADDR_W-1:2];
   assign w_acc   = mm_cyc_i & mm_stb_i & ~r_ack & ~r_err;
   assign w_valid = (w_word <= WORD_W'(4));
   assign w_wr    = w_acc & w_valid & mm_we_i;
   assign w_clr   = (w_wr && (w_word == WORD_W'(3))) ? mm_dat_i[CH_N-1:0] : '0;

   assign pulse_o     = r_pulse;
   assign irq_o       = |(r_event & r_irq_en);
   assign mm_ack_o    = r_ack;
   assign mm_err_o    = r_err;
   assign mm_dat_o    = r_dat;
   assign w_unused_ok = ^{mm_addr_i[1:0], mm_dat_i};

   // An edge is accepted once the synchronised input has disagreed with the
   // debounced level for more than D cycles; MODE picks which directions pulse.
   always_comb begin
      // NOTE: defaults first so no path through the block leaves a bit unassigned (no latch).
      w_accept = '0;
      w_hit    = '0;
      for (int i = 0; i < CH_N; i++) begin
         w_accept[i] = (r_sync[i] != r_level[i]) && (r_cnt[i] >= r_dbnc);
         w_hit[i]    = w_accept[i] && (r_sync[i] ? r_mode[2*i] : r_mode[2*i+1]);
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_word)
         WORD_W'(0): w_rdata[CH_N-1:0]     = r_level;
         WORD_W'(1): w_rdata[2*CH_N-1:0]   = r_mode;
         WORD_W'(2): w_rdata[DB_CNT_W-1:0] = r_dbnc;
         WORD_W'(3): w_rdata[CH_N-1:0]     = r_event;
         WORD_W'(4): w_rdata[CH_N-1:0]     = r_irq_en;
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge mm_clk_i or negedge mm_rst_i) begin
      if (!mm_rst_i) begin
         r_s1    <= '0;
         r_sync  <= '0;
         r_level <= '0;
         r_pulse <= '0;
         r_event <= '0;
         // NOTE: the counter array is small and must restart cleanly, so it is reset explicitly.
         for (int i = 0; i < CH_N; i++) r_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values (s1 -> sync is a true 2-stage chain).
         r_s1    <= sw_i;
         r_sync  <= r_s1;
         r_pulse <= w_hit;
         r_event <= (r_event & ~w_clr) | w_hit;
         for (int i = 0; i < CH_N; i++) begin
            if (r_sync[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_level[i] <= r_sync[i];
               r_cnt[i]   <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + DB_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge mm_clk_i or negedge mm_rst_i) begin
      if (!mm_rst_i) begin
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_dat    <= '0;
         r_mode   <= MODE_RST;
         r_dbnc   <= '0;
         r_irq_en <= '0;
      end else begin
         r_ack <= w_acc & w_valid;
         r_err <= w_acc & ~w_valid;
         if (w_acc) r_dat <= w_rdata;
         if (w_wr) begin
            case (w_word)
               WORD_W'(1): r_mode   <= mm_dat_i[2*CH_N-1:0];
               WORD_W'(2): r_dbnc   <= mm_dat_i[DB_CNT_W-1:0];
               WORD_W'(4): r_irq_en <= mm_dat_i[CH_N-1:0];
               default:    ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_onfi_edge_detect.sv
// Scoreboard bench for onfi_edge_detect: a window-based debounce model predicts
// pulses and bus responses; a negedge monitor pops and compares them.
module tb_onfi_edge_detect;
   localparam int CH_N = 4;

   logic            mm_clk_i = 1'b0;
   logic            mm_rst_i;
   logic [CH_N-1:0] sw_i;
   logic [CH_N-1:0] pulse_o;
   logic            irq_o;
   logic            mm_cyc_i, mm_stb_i, mm_we_i;
   logic [7:0]      mm_addr_i;
   logic [31:0]     mm_dat_i, mm_dat_o;
   logic            mm_ack_o, mm_err_o;

   onfi_edge_detect #(.CH_N(CH_N), .DB_CNT_W(16), .MM_DATA_W(32), .MM_ADDR_W(8)) dut (
      .mm_clk_i(mm_clk_i), .mm_rst_i(mm_rst_i), .sw_i(sw_i), .pulse_o(pulse_o),
      .irq_o(irq_o), .mm_cyc_i(mm_cyc_i), .mm_stb_i(mm_stb_i), .mm_addr_i(mm_addr_i),
      .mm_dat_i(mm_dat_i), .mm_dat_o(mm_dat_o), .mm_we_i(mm_we_i),
      .mm_ack_o(mm_ack_o), .mm_err_o(mm_err_o));

   always #5 mm_clk_i = ~mm_clk_i;

   typedef struct { int cyc; logic [CH_N-1:0] vec; } pulse_t;
   typedef struct { logic err; logic [31:0] data; } bus_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [CH_N-1:0]   m_level, m_event, m_irq_en;
   logic [2*CH_N-1:0] m_mode;
   int                m_dbnc;
   logic              m_ack, m_err;
   logic [CH_N-1:0]   hist[$];
   int                n;
   pulse_t            pq[$];
   bus_t              bq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_level = '0; m_event = '0; m_irq_en = '0; m_mode = {CH_N{2'b10}};
      m_dbnc = 0; m_ack = 1'b0; m_err = 1'b0; n = -1;
      hist.delete(); pq.delete(); bq.delete();
   endtask

   // Level flips when the last D+1 synchronised samples (two cycles old) all
   // disagree with the current level; samples before reset count as 0.
   task automatic model_step();
      logic [CH_N-1:0] hits, nlev, clr;
      bus_t b;
      int   word;
      logic acc;
      hist.push_back(sw_i);
      n = hist.size() - 1;
      hits = '0; nlev = m_level; clr = '0;
      for (int ch = 0; ch < CH_N; ch++) begin
         bit all_diff;
         all_diff = 1'b1;
         for (int j = 0; j <= m_dbnc; j++) begin
            int   idx;
            logic s;
            idx = n - 2 - j;
            s = (idx < 0) ? 1'b0 : hist[idx][ch];
            if (s == m_level[ch]) all_diff = 1'b0;
         end
         if (all_diff) begin
            nlev[ch] = ~m_level[ch];
            if (nlev[ch] ? m_mode[2*ch] : m_mode[2*ch+1]) hits[ch] = 1'b1;
         end
      end
      acc  = mm_cyc_i & mm_stb_i & !m_ack & !m_err;
      word = int'(mm_addr_i[7:2]);
      if (acc) begin
         b.err  = (word > 4);
         b.data = '0;
         case (word)
            0: b.data = 32'(m_level);
            1: b.data = 32'(m_mode);
            2: b.data = 32'(m_dbnc);
            3: b.data = 32'(m_event);
            4: b.data = 32'(m_irq_en);
            default: b.data = '0;
         endcase
         bq.push_back(b);
         if (mm_we_i && !b.err) begin
            case (word)
               1: m_mode   = mm_dat_i[2*CH_N-1:0];
               2: m_dbnc   = int'(mm_dat_i[15:0]);
               3: clr      = mm_dat_i[CH_N-1:0];
               4: m_irq_en = mm_dat_i[CH_N-1:0];
               default: ;
            endcase
         end
      end
      m_ack   = acc && (word <= 4);
      m_err   = acc && (word > 4);
      m_event = (m_event & ~clr) | hits;
      m_level = nlev;
      if (hits != '0) pq.push_back('{n, hits});
   endtask

   initial begin
      reset_model();
      forever begin
         @(posedge mm_clk_i or negedge mm_rst_i);
         if (!mm_rst_i) reset_model();
         else           model_step();
      end
   end

   // Monitor: pops expectations whenever the DUT presents a pulse or a bus termination.
   initial begin
      pulse_t p;
      bus_t   b;
      forever begin
         @(negedge mm_clk_i);
         if (mm_rst_i === 1'b1) begin
            if (pq.size() > 0 && pq[0].cyc == n) begin
               p = pq.pop_front();
               check("pulse_vec", 32'(pulse_o), 32'(p.vec));
            end else if (pulse_o != '0) begin
               check("pulse_unexpected", 32'(pulse_o), 32'h0);
            end
            if (mm_ack_o | mm_err_o) begin
               check("ack_err_exclusive", 32'(mm_ack_o & mm_err_o), 32'h0);
               if (bq.size() == 0) begin
                  check("bus_unexpected", 32'(mm_ack_o | mm_err_o), 32'h0);
               end else begin
                  b = bq.pop_front();
                  check("bus_err", 32'(mm_err_o), 32'(b.err));
                  check("bus_data", mm_dat_o, b.data);
               end
            end
            check("irq_model", 32'(irq_o), 32'(|(m_event & m_irq_en)));
         end
      end
   end

   task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic ack, output logic err);
      bit got;
      got = 1'b0; rd = '0; ack = 1'b0; err = 1'b0;
      mm_cyc_i = 1'b1; mm_stb_i = 1'b1; mm_we_i = we; mm_addr_i = addr; mm_dat_i = wd;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge mm_clk_i); #1;
         if (mm_ack_o | mm_err_o) begin
            got = 1'b1; rd = mm_dat_o; ack = mm_ack_o; err = mm_err_o;
         end
      end
      mm_cyc_i = 1'b0; mm_stb_i = 1'b0; mm_we_i = 1'b0;
      if (!got) check("bus_timeout", 32'h0, 32'h1);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] d);
      logic [31:0] rd; logic a, e;
      bus(1'b1, addr, d, rd, a, e);
   endtask

   task automatic rdreg(input logic [7:0] addr, output logic [31:0] d);
      logic a, e;
      bus(1'b0, addr, 32'h0, d, a, e);
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin @(posedge mm_clk_i); #1; end
   endtask

   initial begin
      logic [31:0] d;
      logic        a, e;
      int          got, cnt;
      mm_rst_i = 1'b0; sw_i = '0; mm_cyc_i = 1'b0; mm_stb_i = 1'b0; mm_we_i = 1'b0;
      mm_addr_i = '0; mm_dat_i = '0;
      repeat (3) @(posedge mm_clk_i);
      #1 mm_rst_i = 1'b1;

      // Reset defaults
      rdreg(8'h00, d); check("rst_state", d, 32'h0);
      rdreg(8'h04, d); check("rst_mode", d, 32'hAA);
      rdreg(8'h08, d); check("rst_dbnc", d, 32'h0);
      rdreg(8'h0C, d); check("rst_event", d, 32'h0);
      rdreg(8'h10, d); check("rst_irq_en", d, 32'h0);
      bus(1'b0, 8'h20, 32'h0, d, a, e);
      check("bad_addr_err", 32'(e), 32'h1);
      check("bad_addr_no_ack", 32'(a), 32'h0);

      // Falling-edge detect, D=0, channel 2
      sw_i[2] = 1'b1; cnt = 0;
      for (int k = 0; k < 10; k++) begin @(posedge mm_clk_i); #1; if (pulse_o != '0) cnt++; end
      check("rise_no_pulse", 32'(cnt), 32'h0);
      sw_i[2] = 1'b0; got = 0; d = '0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge mm_clk_i); #1;
         if (pulse_o != '0 && got == 0) begin got = k; d = 32'(pulse_o); end
      end
      check("fall_latency", 32'(got), 32'd3);
      check("fall_vec", d, 32'h4);
      rdreg(8'h0C, d); check("fall_event", d, 32'h4);

      // Debounce D=5 on channel 0 (both edges enabled)
      wr(8'h08, 32'd5);
      wr(8'h04, 32'hAB);
      sw_i[0] = 1'b1; idle(4); sw_i[0] = 1'b0; cnt = 0;
      for (int k = 0; k < 15; k++) begin @(posedge mm_clk_i); #1; if (pulse_o[0]) cnt++; end
      check("glitch_no_pulse", 32'(cnt), 32'h0);
      rdreg(8'h00, d); check("glitch_state", d, 32'h0);
      sw_i[0] = 1'b1; got = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge mm_clk_i); #1;
         if (pulse_o[0] && got == 0) got = k;
      end
      check("debounce_latency", 32'(got), 32'd8);

      // Both-edge mode and interrupt on channel 1
      wr(8'h04, 32'hAE);
      wr(8'h10, 32'h2);
      cnt = 0;
      for (int t = 0; t < 2; t++) begin
         sw_i[1] = ~sw_i[1];
         for (int k = 0; k < 12; k++) begin @(posedge mm_clk_i); #1; if (pulse_o[1]) cnt++; end
      end
      check("both_pulses", 32'(cnt), 32'd2);
      check("irq_set", 32'(irq_o), 32'h1);
      wr(8'h0C, 32'h2);
      idle(1);
      check("irq_cleared", 32'(irq_o), 32'h0);
      // W1C accepted on the same edge the channel-1 edge is accepted (edge 3+D)
      sw_i[1] = 1'b1;
      idle(7);
      wr(8'h0C, 32'h2);
      rdreg(8'h0C, d); check("set_wins_over_clear", 32'(d[1]), 32'h1);
      check("irq_after_set_wins", 32'(irq_o), 32'h1);

      // Randomised traffic against the model
      idle(12);
      wr(8'h08, 32'($urandom_range(0, 3)));
      for (int it = 0; it < 400; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6) begin
            for (int c = 0; c < CH_N; c++) if ($urandom_range(0, 7) == 0) sw_i[c] = ~sw_i[c];
            idle(1);
         end else if (r == 6) begin
            rdreg(8'($urandom_range(0, 9) * 4), d);
         end else if (r == 7) begin
            wr(8'h0C, 32'($urandom_range(0, 15)));
         end else if (r == 8) begin
            wr(8'h10, 32'($urandom_range(0, 15)));
         end else begin
            wr(8'h04, 32'($urandom_range(0, 255)));
         end
      end

      // Async reset mid-count and during a pending strobe
      idle(12);
      wr(8'h08, 32'd5);
      wr(8'h0C, 32'hF);
      wr(8'h10, 32'hF);
      sw_i[0] = ~sw_i[0];
      idle(3);
      mm_cyc_i = 1'b1; mm_stb_i = 1'b1; mm_we_i = 1'b0; mm_addr_i = 8'h04;
      #2 mm_rst_i = 1'b0;
      #1;
      check("rst_pulse", 32'(pulse_o), 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      check("rst_ack", 32'(mm_ack_o), 32'h0);
      check("rst_err", 32'(mm_err_o), 32'h0);
      check("rst_dat", mm_dat_o, 32'h0);
      mm_cyc_i = 1'b0; mm_stb_i = 1'b0;
      repeat (2) @(posedge mm_clk_i);
      #1 mm_rst_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge mm_clk_i); #1;
         check("no_ack_after_abort", 32'(mm_ack_o | mm_err_o), 32'h0);
      end
      rdreg(8'h04, d); check("rst2_mode", d, 32'hAA);
      rdreg(8'h08, d); check("rst2_dbnc", d, 32'h0);
      rdreg(8'h0C, d); check("rst2_event", d, 32'h0);
      rdreg(8'h10, d); check("rst2_irq_en", d, 32'h0);

      idle(10);
      check("pulse_queue_drained", 32'(pq.size()), 32'h0);
      check("bus_queue_drained", 32'(bq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
